// File: rtl/writeback_control_pkg.sv
`default_nettype none
// ============================================================================
// writeback_control_pkg : shared sequencer state encoding and default widths
// Rev 1.0 - initial release
// ============================================================================
package writeback_control_pkg;

  localparam int WB_DATA_W = 16;
  localparam int WB_ADDR_W = 19;
  localparam int WB_RAM_AW = 12;

  // Encoding values are shared with the fetch controller; keep them in sync.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_RAM  = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_WR_REQ  = 3'd3;
  localparam logic [2:0] ST_WR_WAIT = 3'd4;
  localparam logic [2:0] ST_NEXT    = 3'd5;
  localparam logic [2:0] ST_FINISH  = 3'd6;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    RD_RAM  = ST_RD_RAM,
    CAPTURE = ST_CAPTURE,
    WR_REQ  = ST_WR_REQ,
    WR_WAIT = ST_WR_WAIT,
    NEXT    = ST_NEXT,
    FINISH  = ST_FINISH
  } wb_state_e;

endpackage
`default_nettype wire

// File: rtl/writeback_control.sv
`default_nettype none
// ============================================================================
// writeback_control : drains three result RAMs word by word into SDRAM
// Rev 1.0 - initial release
// ============================================================================
module writeback_control
  import writeback_control_pkg::*;
#(
  parameter int DATA_W    = WB_DATA_W,
  parameter int ADDR_W    = WB_ADDR_W,
  parameter int RAM_AW    = WB_RAM_AW,
  parameter int NUM_WORDS = 4096
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_baseAddr0,
  input  logic [ADDR_W-1:0] i_baseAddr1,
  input  logic [ADDR_W-1:0] i_baseAddr2,
  input  logic [DATA_W-1:0] i_ramData0,
  input  logic [DATA_W-1:0] i_ramData1,
  input  logic [DATA_W-1:0] i_ramData2,
  input  logic              i_sdramReady,
  output logic              o_rdRam0,
  output logic              o_rdRam1,
  output logic              o_rdRam2,
  output logic [RAM_AW-1:0] o_addrToRam,
  output logic              o_wrSdram,
  output logic [ADDR_W-1:0] o_addrToSdram,
  output logic [DATA_W-1:0] o_dataToSdram,
  output logic              o_busy,
  output logic              o_finish
);

  localparam logic [RAM_AW:0] c_LAST_IDX = (RAM_AW+1)'(NUM_WORDS - 1);

  wb_state_e         r_state;
  wb_state_e         w_next;
  logic [RAM_AW:0]   r_index;
  logic [1:0]        r_ch;
  logic [DATA_W-1:0] r_data;

  logic [ADDR_W-1:0] w_base;
  logic [DATA_W-1:0] w_ramData;
  logic [ADDR_W-1:0] w_sdramAddr;

  always_comb begin
    w_base    = i_baseAddr0;
    w_ramData = i_ramData0;
    case (r_ch)
      2'd1: begin w_base = i_baseAddr1; w_ramData = i_ramData1; end
      2'd2: begin w_base = i_baseAddr2; w_ramData = i_ramData2; end
      default: ;
    endcase
  end

  // Address arithmetic wraps modulo 2^ADDR_W by construction.
  assign w_sdramAddr   = w_base + ADDR_W'(r_index);
  assign o_addrToRam   = r_index[RAM_AW-1:0];
  assign o_dataToSdram = r_data;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    o_rdRam0      = 1'b0;
    o_rdRam1      = 1'b0;
    o_rdRam2      = 1'b0;
    o_wrSdram     = 1'b0;
    o_addrToSdram = '0;
    o_busy        = 1'b1;
    o_finish      = 1'b0;
    case (r_state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) w_next = RD_RAM;
      end
      RD_RAM: begin
        o_rdRam0 = (r_ch == 2'd0);
        o_rdRam1 = (r_ch == 2'd1);
        o_rdRam2 = (r_ch == 2'd2);
        w_next   = CAPTURE;
      end
      CAPTURE: w_next = WR_REQ;
      WR_REQ: begin
        o_wrSdram     = 1'b1;
        o_addrToSdram = w_sdramAddr;
        w_next        = WR_WAIT;
      end
      WR_WAIT: begin
        o_addrToSdram = w_sdramAddr;
        if (i_sdramReady) w_next = (r_ch == 2'd2) ? NEXT : RD_RAM;
      end
      NEXT: w_next = (r_index == c_LAST_IDX) ? FINISH : RD_RAM;
      FINISH: begin
        o_finish = 1'b1;
        w_next   = IDLE;
      end
      default: begin
        o_busy = 1'b0;
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_index <= '0;
      r_ch    <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_index <= '0;
          r_ch    <= '0;
        end
        CAPTURE: r_data <= w_ramData;
        WR_WAIT: if (i_sdramReady) r_ch <= (r_ch == 2'd2) ? 2'd0 : r_ch + 2'd1;
        NEXT:    if (r_index != c_LAST_IDX) r_index <= r_index + 1'b1;
        FINISH:  r_index <= '0;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_writeback_control.sv
`default_nettype none
// ============================================================================
// tb_writeback_control : randomized drain runs checked against a write-list model
// Rev 1.0 - initial release
// ============================================================================
module tb_writeback_control;

  localparam int DW = 16;
  localparam int AW = 19;
  localparam int RW = 12;
  localparam int NW = 4;
  localparam int NWR = NW * 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base0 = '0, base1 = '0, base2 = '0;
  logic [DW-1:0] rdata0 = '0, rdata1 = '0, rdata2 = '0;
  logic          ready = 1'b0;
  logic          rd0, rd1, rd2, wr, busy, fin;
  logic [RW-1:0] ram_addr;
  logic [AW-1:0] sd_addr;
  logic [DW-1:0] sd_data;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem [3][NW];
  logic [AW-1:0] exp_addr [NWR];
  logic [DW-1:0] exp_data [NWR];
  int            rd_conflicts = 0;

  always #5 clk = ~clk;

  writeback_control #(.DATA_W(DW), .ADDR_W(AW), .RAM_AW(RW), .NUM_WORDS(NW)) dut (
    .i_clk(clk), .i_reset(reset_n), .i_start(start),
    .i_baseAddr0(base0), .i_baseAddr1(base1), .i_baseAddr2(base2),
    .i_ramData0(rdata0), .i_ramData1(rdata1), .i_ramData2(rdata2),
    .i_sdramReady(ready),
    .o_rdRam0(rd0), .o_rdRam1(rd1), .o_rdRam2(rd2), .o_addrToRam(ram_addr),
    .o_wrSdram(wr), .o_addrToSdram(sd_addr), .o_dataToSdram(sd_data),
    .o_busy(busy), .o_finish(fin)
  );

  // Synchronous-read RAM environment model, one read port per channel.
  always @(posedge clk) begin
    if (rd0) rdata0 <= mem[0][ram_addr];
    if (rd1) rdata1 <= mem[1][ram_addr];
    if (rd2) rdata2 <= mem[2][ram_addr];
    if (int'(rd0) + int'(rd1) + int'(rd2) > 1) rd_conflicts++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {11'd0, rd0, rd1, rd2, ram_addr, wr, sd_addr, sd_data, busy, fin};
  endfunction

  // Expected write order: index-major, channel 0,1,2; address wraps mod 2^AW.
  task automatic build_model(input logic [AW-1:0] b0, input logic [AW-1:0] b1,
                             input logic [AW-1:0] b2);
    logic [AW-1:0] b [3];
    b[0] = b0; b[1] = b1; b[2] = b2;
    base0 = b0; base1 = b1; base2 = b2;
    for (int i = 0; i < NW; i++)
      for (int c = 0; c < 3; c++) begin
        mem[c][i] = DW'($urandom);
        exp_addr[i*3+c] = AW'((longint'(b[c]) + i) % (longint'(1) << AW));
        exp_data[i*3+c] = mem[c][i];
      end
  endtask

  // Starts a drain and plays the SDRAM side: ready d cycles after each request,
  // optionally also on the request cycle itself. abort_k >= 0 resets the DUT
  // while waiting on write number abort_k-1.
  task automatic run_drain(input string nm, input int d, input bit early,
                           input bit start_mid, input int exp_cycles, input int abort_k);
    int k = 0, nfin = 0, cyc = 0, wcnt = 0, extra = 0;
    bit waiting = 0, aborted = 0;
    @(negedge clk);
    start = 1'b1;
    while (nfin == 0 && cyc < 2000 && !aborted) begin
      @(negedge clk);
      cyc++;
      start = start_mid && (cyc == 20);
      ready = 1'b0;
      if (wr) begin
        if (k < NWR) begin
          chk({nm, "_addr"}, 64'(sd_addr), 64'(exp_addr[k]));
          chk({nm, "_data"}, 64'(sd_data), 64'(exp_data[k]));
        end else extra++;
        k++;
        waiting = 1;
        wcnt = d;
        if (early) ready = 1'b1;
      end else if (waiting) begin
        if (k == abort_k) begin
          reset_n = 1'b0;
          #1;
          chk({nm, "_abort_outs"}, all_outs(), 64'd0);
          aborted = 1;
        end else begin
          if (k <= NWR) chk({nm, "_hold_addr"}, 64'(sd_addr), 64'(exp_addr[k-1]));
          wcnt--;
          if (wcnt == 0) begin
            ready = 1'b1;
            waiting = 0;
          end
        end
      end
      if (fin) nfin++;
    end
    ready = 1'b0;
    start = 1'b0;
    if (aborted) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (fin || wr) nfin++;
      end
      chk({nm, "_no_finish_in_reset"}, 64'(nfin), 64'd0);
      reset_n = 1'b1;
      return;
    end
    chk({nm, "_finish_seen"}, 64'(nfin), 64'd1);
    chk({nm, "_write_count"}, 64'(k), 64'(NWR));
    chk({nm, "_extra_writes"}, 64'(extra), 64'd0);
    if (exp_cycles > 0) chk({nm, "_latency"}, 64'(cyc), 64'(exp_cycles));
    @(negedge clk);
    chk({nm, "_busy_after"}, 64'(busy), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (fin || wr || busy) nfin++;
    end
    chk({nm, "_quiet_after"}, 64'(nfin), 64'd1);
  endtask

  initial begin
    build_model(19'h00100, 19'h20000, 19'h40000);
    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 64'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outs", all_outs(), 64'd0);
    end

    build_model(19'h00100, 19'h20000, 19'h40000);
    run_drain("basic", 2, 1'b0, 1'b0, 0, -1);

    build_model(AW'($urandom), AW'($urandom), AW'($urandom));
    run_drain("min_latency", 1, 1'b0, 1'b0, NW * 13 + 1, -1);

    build_model(AW'($urandom), AW'($urandom), AW'($urandom));
    run_drain("handshake", 5, 1'b1, 1'b0, NW * (3 * (3 + 5) + 1) + 1, -1);

    build_model(AW'($urandom), AW'($urandom), 19'h7FFFE);
    run_drain("wrap", 2, 1'b0, 1'b0, 0, -1);

    build_model(AW'($urandom), AW'($urandom), AW'($urandom));
    run_drain("abort", 2, 1'b0, 1'b0, 0, 8);
    @(negedge clk);
    chk("abort_idle_outs", all_outs(), 64'd0);
    build_model(AW'($urandom), AW'($urandom), AW'($urandom));
    run_drain("restart", 3, 1'b0, 1'b0, 0, -1);

    build_model(AW'($urandom), AW'($urandom), AW'($urandom));
    run_drain("start_busy", 2, 1'b0, 1'b1, NW * (3 * (3 + 2) + 1) + 1, -1);

    chk("rd_onehot", 64'(rd_conflicts), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/writeback_control.md
Name: writeback_control

Overview:
- Write-back sequencer for the layer engine; counterpart of the SDRAM-to-RAM fetch path.
- Drains three on-chip result RAMs (channels 0/1/2) word by word into SDRAM, each channel at its own base address.
- Per index, channels are written in order 0, 1, 2. Each write is a single-word request/ready handshake to the SDRAM controller.
- Pulses o_finish once all NUM_WORDS indices are written.

Parameters:
DATA_W, 16, width of one RAM/SDRAM data word
ADDR_W, 19, SDRAM word-address width
RAM_AW, 12, on-chip RAM address width
NUM_WORDS, 4096, words per channel (1..2^RAM_AW)

Ports:
i_clk  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_start  in  1  start pulse; sampled only in IDLE
i_baseAddr0  in  ADDR_W  SDRAM base address, channel 0
i_baseAddr1  in  ADDR_W  SDRAM base address, channel 1
i_baseAddr2  in  ADDR_W  SDRAM base address, channel 2
i_ramData0  in  DATA_W  channel-0 RAM read data (1-cycle synchronous read)
i_ramData1  in  DATA_W  channel-1 RAM read data
i_ramData2  in  DATA_W  channel-2 RAM read data
i_sdramReady  in  1  SDRAM write-complete strobe
o_rdRam0  out  1  channel-0 RAM read enable
o_rdRam1  out  1  channel-1 RAM read enable
o_rdRam2  out  1  channel-2 RAM read enable
o_addrToRam  out  RAM_AW  RAM read address (current index)
o_wrSdram  out  1  SDRAM write request, 1-cycle pulse
o_addrToSdram  out  ADDR_W  SDRAM write address
o_dataToSdram  out  DATA_W  SDRAM write data
o_busy  out  1  high in every state except IDLE
o_finish  out  1  1-cycle completion pulse

Behaviour:
- Interface: one clock (i_clk). Reset i_reset is asynchronous and active-low.
- Reset values:
  - state = IDLE; index = 0; ch = 0; data register = 0.
  - All outputs 0.
- Reset mid-operation aborts immediately. No o_finish is produced and no further o_wrSdram is issued.
- Registered state: state, index (RAM_AW+1 bits), ch (2 bits, values 0..2), captured data register.
- States and transitions:
  - IDLE: index = 0, ch = 0. Go to RD_RAM when i_start = 1, otherwise stay.
  - RD_RAM: o_rdRam[ch] = 1 (only that one), o_addrToRam = index. Next state CAPTURE.
  - CAPTURE: latch i_ramData[ch] into the data register. Next state WR_REQ.
  - WR_REQ: o_wrSdram = 1 for exactly one cycle. Next state WR_WAIT.
  - WR_WAIT: hold until i_sdramReady = 1. Then:
    - if ch < 2: ch += 1, go to RD_RAM;
    - if ch == 2: ch = 0, go to NEXT.
  - NEXT:
    - if index == NUM_WORDS-1: go to FINISH;
    - otherwise index += 1, go to RD_RAM.
  - FINISH: o_finish = 1 for one cycle, clear index, go to IDLE.
- Addressing and data:
  - o_addrToSdram = i_baseAddr[ch] + index, zero-extended, result truncated mod 2^ADDR_W (wraps silently).
  - o_addrToSdram is valid and stable in WR_REQ and WR_WAIT; it is 0 in IDLE and FINISH.
  - o_dataToSdram = data register, stable from WR_REQ through the ready cycle.
  - o_addrToRam = index[RAM_AW-1:0] in all states.
- i_sdramReady is ignored outside WR_WAIT, including a ready coinciding with WR_REQ. Minimum write turnaround is therefore 2 cycles.
- i_start is ignored while o_busy = 1.
- Base addresses are sampled combinationally. They must remain stable while o_busy = 1.
- Latency:
  - Per channel write: 3 + W cycles, W = WR_WAIT cycles (≥ 1).
  - Per index: 3 channel writes + 1 NEXT cycle.
  - Minimum total from start acceptance to o_finish: NUM_WORDS × 13 + 1 cycles.
- NUM_WORDS = 1: a single pass over the three channels, then FINISH.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE, RD_RAM, CAPTURE, WR_REQ, WR_WAIT, NEXT, FINISH), shared with the fetch controller's encoding file;
  - default ADDR_W, RAM_AW, DATA_W constants.
- Single module; no sub-module needed.
- The 3:1 base-address/data mux is inline combinational logic.

Test Plan:
- Reset/idle: hold i_reset = 0, then release with no i_start → all outputs 0, o_busy = 0 for 20 cycles.
- Basic drain: NUM_WORDS = 4, bases 0x00100/0x20000/0x40000, RAM model data = {ch, index}, ready 2 cycles after each request → 12 writes in order to 0x00100, 0x20000, 0x40000, 0x00101, …, each with matching data; one o_finish; o_busy falls the cycle after.
- Handshake timing: ready asserted on the same cycle as o_wrSdram and again 5 cycles later → that write is completed only by the later ready; exactly one o_wrSdram pulse per write.
- Address wrap: i_baseAddr2 = 0x7FFFE, NUM_WORDS = 4 → channel-2 addresses 0x7FFFE, 0x7FFFF, 0x00000, 0x00001.
- Abort: assert i_reset = 0 while in WR_WAIT at index 2 → outputs 0 immediately; no o_finish; a fresh i_start restarts at index 0, channel 0.
- Start while busy: pulse i_start mid-run → write sequence and count unchanged; exactly one o_finish.
